hdmi_encoder: RTL and testbench

- Transmit-side counterpart of the HDMI receive path. Converts 8-bit blue/green/red pixel data plus hsync/vsync/de into three 10-bit DC-balanced TMDS symbols per pixel clock, using the DVI 1.0 TMDS algorithm.
- Sits between the video output pipeline and the 10:1 serializers.
- Parallel bit 0 of each symbol is transmitted first.

---
 rtl/hdmi_pkg.sv | 33 +++
 rtl/hdmi_encoder_if.sv | 27 ++
 rtl/tmds_channel_encoder.sv | 96 +++++++++
 rtl/hdmi_encoder.sv | 50 +++++
 tb/tb_hdmi_encoder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_pkg.sv
// Shared TMDS constants for the HDMI transmit and receive paths.
// Holds the control tokens, symbol and disparity widths, and small helpers.
package hdmi_pkg;

  localparam int SYM_W = 10;
  localparam int CNT_W = 5;

  localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;
  localparam logic [SYM_W-1:0] CTRL_RESET    = CTRL_TOKEN_00;

  // c is {c1, c0}
  function automatic logic [SYM_W-1:0] ctrl_token(input logic [1:0] c);
    logic [SYM_W-1:0] tok;
    case (c)
      2'b00:   tok = CTRL_TOKEN_00;
      2'b01:   tok = CTRL_TOKEN_01;
      2'b10:   tok = CTRL_TOKEN_10;
      default: tok = CTRL_TOKEN_11;
    endcase
    return tok;
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

endpackage

// File: rtl/hdmi_encoder_if.sv
// Video-side bundle of the HDMI encoder: pixel/sync inputs and TMDS symbol outputs.
// No handshake: every input is sampled on every clk_1x_in edge, every output is valid every clock, and de_out marks pixel vs control symbols.
interface hdmi_encoder_if;
  import hdmi_pkg::*;

  logic [7:0]       pixel_data_b;
  logic [7:0]       pixel_data_g;
  logic [7:0]       pixel_data_r;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [SYM_W-1:0] tmds_ch0;
  logic [SYM_W-1:0] tmds_ch1;
  logic [SYM_W-1:0] tmds_ch2;
  logic             de_out;

  modport master (
    output pixel_data_b, pixel_data_g, pixel_data_r, hsync, vsync, de,
    input  tmds_ch0, tmds_ch1, tmds_ch2, de_out
  );

  modport slave (
    input  pixel_data_b, pixel_data_g, pixel_data_r, hsync, vsync, de,
    output tmds_ch0, tmds_ch1, tmds_ch2, de_out
  );

endinterface

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: transition-minimising stage, then DC-balancing stage with
// a running disparity that is cleared by every control period.
module tmds_channel_encoder #(
  parameter logic [hdmi_pkg::SYM_W-1:0] CTRL_RESET = hdmi_pkg::CTRL_RESET
) (
  input  logic       clk_1x_in,
  input  logic       reset_in,
  input  logic [7:0] data,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
  output logic [9:0] symbol
);
  import hdmi_pkg::*;

  logic [3:0] n1_d;
  logic       use_xnor;
  logic [8:0] q_m;
  logic [3:0] n1q_d;

  always_comb begin
    n1_d     = ones8(data);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
    q_m[0]   = data[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
    q_m[8]   = ~use_xnor;
    n1q_d    = ones8(q_m[7:0]);
  end

  logic [8:0]              qm_r;
  logic [3:0]              n1_r;
  logic [3:0]              n0_r;
  logic                    de_r;
  logic [1:0]              c_r;
  logic signed [CNT_W-1:0] cnt;

  always_ff @(posedge clk_1x_in) begin
    if (reset_in) begin
      qm_r <= '0;
      n1_r <= '0;
      n0_r <= '0;
      de_r <= 1'b0;
      c_r  <= 2'b00;
    end else begin
      qm_r <= q_m;
      n1_r <= n1q_d;
      n0_r <= 4'd8 - n1q_d;
      de_r <= de;
      c_r  <= {c1, c0};
    end
  end

  logic signed [CNT_W-1:0] diff;
  logic signed [CNT_W-1:0] two_q8;
  logic signed [CNT_W-1:0] two_nq8;
  logic                    balanced;
  logic                    invert;
  logic [9:0]              sym_d;
  logic signed [CNT_W-1:0] cnt_d;

  // cnt equals the exact running ones-minus-zeros of every emitted 10-bit word
  always_comb begin
    diff     = $signed({1'b0, n1_r}) - $signed({1'b0, n0_r});
    two_q8   = {3'b000, qm_r[8], 1'b0};
    two_nq8  = {3'b000, ~qm_r[8], 1'b0};
    balanced = (cnt == '0) || (n1_r == n0_r);
    invert   = (!cnt[CNT_W-1] && (cnt != '0) && (n1_r > n0_r)) ||
               (cnt[CNT_W-1] && (n0_r > n1_r));
    sym_d    = ctrl_token(c_r);
    cnt_d    = '0;
    if (de_r) begin
      if (balanced) begin
        sym_d = {~qm_r[8], qm_r[8], qm_r[8] ? qm_r[7:0] : ~qm_r[7:0]};
        cnt_d = cnt + (qm_r[8] ? diff : -diff);
      end else if (invert) begin
        sym_d = {1'b1, qm_r[8], ~qm_r[7:0]};
        cnt_d = cnt + two_q8 - diff;
      end else begin
        sym_d = {1'b0, qm_r[8], qm_r[7:0]};
        cnt_d = cnt + diff - two_nq8;
      end
    end
  end

  always_ff @(posedge clk_1x_in) begin
    if (reset_in) begin
      symbol <= CTRL_RESET;
      cnt    <= '0;
    end else begin
      symbol <= sym_d;
      cnt    <= cnt_d;
    end
  end

endmodule

// File: rtl/hdmi_encoder.sv
// Three-channel DVI/HDMI TMDS encoder: blue+sync, green, red; 2-clock latency.
// de_out is de delayed to line up with the encoded symbols.
module hdmi_encoder #(
  parameter logic [hdmi_pkg::SYM_W-1:0] CTRL_RESET = hdmi_pkg::CTRL_RESET
) (
  input logic           clk_1x_in,
  input logic           reset_in,
  hdmi_encoder_if.slave vid
);

  tmds_channel_encoder #(.CTRL_RESET(CTRL_RESET)) u_ch0 (
    .clk_1x_in (clk_1x_in),
    .reset_in  (reset_in),
    .data      (vid.pixel_data_b),
    .c0        (vid.hsync),
    .c1        (vid.vsync),
    .de        (vid.de),
    .symbol    (vid.tmds_ch0)
  );

  tmds_channel_encoder #(.CTRL_RESET(CTRL_RESET)) u_ch1 (
    .clk_1x_in (clk_1x_in),
    .reset_in  (reset_in),
    .data      (vid.pixel_data_g),
    .c0        (1'b0),
    .c1        (1'b0),
    .de        (vid.de),
    .symbol    (vid.tmds_ch1)
  );

  tmds_channel_encoder #(.CTRL_RESET(CTRL_RESET)) u_ch2 (
    .clk_1x_in (clk_1x_in),
    .reset_in  (reset_in),
    .data      (vid.pixel_data_r),
    .c0        (1'b0),
    .c1        (1'b0),
    .de        (vid.de),
    .symbol    (vid.tmds_ch2)
  );

  logic [1:0] de_pipe;

  always_ff @(posedge clk_1x_in) begin
    if (reset_in) de_pipe <= 2'b00;
    else          de_pipe <= {de_pipe[0], vid.de};
  end

  assign vid.de_out = de_pipe[1];

endmodule

// File: tb/tb_hdmi_encoder.sv
// Self-checking bench for hdmi_encoder: directed token/disparity/reset steps,
// then random video with a loopback decode and running-disparity bound.
module tb_hdmi_encoder;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
    logic       hs;
    logic       vs;
    logic       de;
  } px_t;

  logic clk_1x_in = 1'b0;
  logic reset_in  = 1'b1;

  hdmi_encoder_if vid ();

  hdmi_encoder dut (
    .clk_1x_in (clk_1x_in),
    .reset_in  (reset_in),
    .vid       (vid)
  );

  always #5 clk_1x_in = ~clk_1x_in;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cnt_m[3];
  int  disp[3];
  px_t s1 = '0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = 10'b1101010100;
      2'b01:   t = 10'b0010101011;
      2'b10:   t = 10'b0101010100;
      default: t = 10'b1010101011;
    endcase
    return t;
  endfunction

  // Reference encoder from the TMDS rules; cnt_m holds each channel's disparity.
  function automatic logic [9:0] model_enc(input int ch, input logic [7:0] d,
                                           input logic de, input logic [1:0] c);
    logic [8:0] qm;
    logic [9:0] s;
    logic       xn;
    int n1, n1q, n0q;
    if (!de) begin
      cnt_m[ch] = 0;
      return token(c);
    end
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (cnt_m[ch] == 0 || n1q == n0q) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_m[ch] += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((cnt_m[ch] > 0 && n1q > n0q) || (cnt_m[ch] < 0 && n0q > n1q)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      cnt_m[ch] += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      cnt_m[ch] += n1q - n0q - 2 * int'(!qm[8]);
    end
    return s;
  endfunction

  // Receive-side decode used for the loopback check.
  function automatic void dec(input logic [9:0] s, output logic [7:0] d,
                              output logic is_ctrl, output logic [1:0] c);
    logic [7:0] q;
    is_ctrl = 1'b1;
    c = 2'b00;
    if      (s == token(2'b00)) c = 2'b00;
    else if (s == token(2'b01)) c = 2'b01;
    else if (s == token(2'b10)) c = 2'b10;
    else if (s == token(2'b11)) c = 2'b11;
    else is_ctrl = 1'b0;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
  endfunction

  // Drive one clock of input; check the outputs produced at that edge.
  task automatic cycle(input px_t x, input logic rst);
    px_t        cur;
    logic [9:0] e[3];
    logic [9:0] o[3];
    logic [7:0] pix[3];
    logic [7:0] dd;
    logic       isc;
    logic [1:0] cc;
    vid.pixel_data_b = x.b;
    vid.pixel_data_g = x.g;
    vid.pixel_data_r = x.r;
    vid.hsync        = x.hs;
    vid.vsync        = x.vs;
    vid.de           = x.de;
    reset_in         = rst;
    @(posedge clk_1x_in);
    #1;
    o[0] = vid.tmds_ch0;
    o[1] = vid.tmds_ch1;
    o[2] = vid.tmds_ch2;
    if (rst) begin
      for (int ch = 0; ch < 3; ch++) begin
        e[ch] = 10'b1101010100;
        cnt_m[ch] = 0;
        disp[ch] = 0;
      end
      chk("de_out_rst", {31'd0, vid.de_out}, 32'd0);
      s1 = '0;
    end else begin
      cur = s1;
      e[0] = model_enc(0, cur.b, cur.de, {cur.vs, cur.hs});
      e[1] = model_enc(1, cur.g, cur.de, 2'b00);
      e[2] = model_enc(2, cur.r, cur.de, 2'b00);
      pix[0] = cur.b;
      pix[1] = cur.g;
      pix[2] = cur.r;
      chk("de_out", {31'd0, vid.de_out}, {31'd0, cur.de});
      for (int ch = 0; ch < 3; ch++) begin
        dec(o[ch], dd, isc, cc);
        if (cur.de) begin
          chk($sformatf("ch%0d_not_ctrl", ch), {31'd0, isc}, 32'd0);
          chk($sformatf("ch%0d_pixel", ch), {24'd0, dd}, {24'd0, pix[ch]});
          disp[ch] += 2 * $countones(o[ch]) - 10;
          chk($sformatf("ch%0d_disp_bound(%0d)", ch, disp[ch]),
              {31'd0, (disp[ch] >= -10 && disp[ch] <= 10)}, 32'd1);
        end else begin
          chk($sformatf("ch%0d_ctrl", ch), {29'd0, isc, cc},
              {29'd0, 1'b1, (ch == 0) ? {cur.vs, cur.hs} : 2'b00});
          disp[ch] = 0;
        end
      end
      s1 = x;
    end
    for (int ch = 0; ch < 3; ch++)
      chk($sformatf("ch%0d_sym", ch), {22'd0, o[ch]}, {22'd0, e[ch]});
  endtask

  function automatic px_t mk(input logic de, input logic [7:0] b, input logic [7:0] g,
                             input logic [7:0] r, input logic vs, input logic hs);
    px_t p;
    p.b = b; p.g = g; p.r = r; p.vs = vs; p.hs = hs; p.de = de;
    return p;
  endfunction

  function automatic px_t rand_px(input logic de);
    return mk(de, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endfunction

  px_t idle;
  px_t z0;

  initial begin
    idle = mk(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    z0   = mk(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    // reset held 3 clocks, then released in control period
    repeat (3) cycle(idle, 1'b1);
    chk("rst_ch0", {22'd0, vid.tmds_ch0}, 32'h354);
    chk("rst_ch1", {22'd0, vid.tmds_ch1}, 32'h354);
    chk("rst_ch2", {22'd0, vid.tmds_ch2}, 32'h354);
    repeat (3) cycle(idle, 1'b0);
    chk("idle_ch0", {22'd0, vid.tmds_ch0}, 32'h354);

    // control tokens on channel 0
    cycle(mk(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1), 1'b0);
    cycle(mk(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0), 1'b0);
    chk("tok01_ch0", {22'd0, vid.tmds_ch0}, 32'h0AB);
    cycle(mk(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1), 1'b0);
    chk("tok10_ch0", {22'd0, vid.tmds_ch0}, 32'h154);
    cycle(idle, 1'b0);
    chk("tok11_ch0", {22'd0, vid.tmds_ch0}, 32'h2AB);
    chk("tok11_ch1", {22'd0, vid.tmds_ch1}, 32'h354);
    chk("tok11_ch2", {22'd0, vid.tmds_ch2}, 32'h354);
    cycle(idle, 1'b0);

    // disparity tracking: blue zeros x3, green 0xFF on the first
    cycle(mk(1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0), 1'b0);
    cycle(z0, 1'b0);
    chk("zeros0_ch0", {22'd0, vid.tmds_ch0}, 32'h100);
    chk("ones_ch1", {22'd0, vid.tmds_ch1}, 32'h200);
    cycle(z0, 1'b0);
    chk("zeros1_ch0", {22'd0, vid.tmds_ch0}, 32'h3FF);
    cycle(idle, 1'b0);
    chk("zeros2_ch0", {22'd0, vid.tmds_ch0}, 32'h100);
    chk("zeros2_de_out", {31'd0, vid.de_out}, 32'd1);
    cycle(idle, 1'b0);

    // control period clears disparity
    cycle(z0, 1'b0);
    cycle(idle, 1'b0);
    chk("clr0_ch0", {22'd0, vid.tmds_ch0}, 32'h100);
    cycle(z0, 1'b0);
    chk("clr1_ch0", {22'd0, vid.tmds_ch0}, 32'h354);
    cycle(idle, 1'b0);
    chk("clr2_ch0", {22'd0, vid.tmds_ch0}, 32'h100);
    cycle(idle, 1'b0);

    // data burst interrupted by reset
    repeat (40) cycle(rand_px(1'b1), 1'b0);
    cycle(rand_px(1'b1), 1'b1);
    chk("midrst_ch0", {22'd0, vid.tmds_ch0}, 32'h354);
    chk("midrst_ch1", {22'd0, vid.tmds_ch1}, 32'h354);
    chk("midrst_ch2", {22'd0, vid.tmds_ch2}, 32'h354);
    cycle(rand_px(1'b1), 1'b0);
    chk("postrst_ch0", {22'd0, vid.tmds_ch0}, 32'h354);
    chk("postrst_de_out", {31'd0, vid.de_out}, 32'd0);

    // random video with occasional blanking runs
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        int n;
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) cycle(rand_px(1'b0), 1'b0);
      end else begin
        cycle(rand_px(1'b1), 1'b0);
      end
    end
    repeat (3) cycle(idle, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
